// File: rtl/reg_32_writeback_unit_pkg.sv
// Shared constants for the 32-entry register file write side.
// Widths here match the register file and decode stage.
package reg_32_writeback_unit_pkg;

    localparam int REG_32_WORD_LEN  = 32;
    localparam int REG_32_ADDR_LEN  = 5;
    localparam int REG_32_TOTALSIZE = 32;

endpackage

// File: rtl/reg_32_wb_fifo.sv
// In-order sync FIFO; every slot, its valid bit and the tail
// pointer are visible so the owner can scan pending entries.
module reg_32_wb_fifo #(
    parameter int W     = 37,
    parameter int DEPTH = 4,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_push,
    input  logic [W-1:0]            i_wdata,
    input  logic                    i_pop,
    output logic [W-1:0]            o_rdata,
    output logic [CW-1:0]           o_count,
    output logic                    o_full,
    output logic                    o_empty,
    output logic [DEPTH-1:0][W-1:0] o_mem,
    output logic [DEPTH-1:0]        o_valid,
    output logic [PW-1:0]           o_tail
);

    logic [DEPTH-1:0][W-1:0] mem_q, mem_d;
    logic [DEPTH-1:0]        valid_q, valid_d;
    logic [PW-1:0]           head_q, head_d;
    logic [PW-1:0]           tail_q, tail_d;
    logic [CW-1:0]           count_q, count_d;
    logic                    do_push;
    logic                    do_pop;

    assign o_full  = (count_q == CW'(DEPTH));
    assign o_empty = (count_q == '0);
    assign do_push = i_push && !o_full;
    assign do_pop  = i_pop && !o_empty;

    // Next-state: slot write, pointer advance, occupancy tracking.
    always_comb begin
        mem_d   = mem_q;
        valid_d = valid_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (do_pop) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + 1'b1;
        end
        if (do_push) begin
            mem_d[tail_q]   = i_wdata;
            valid_d[tail_q] = 1'b1;
            tail_d          = tail_q + 1'b1;
        end
        count_d = count_q + CW'(do_push) - CW'(do_pop);
    end

    // State registers; reset empties the queue.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            mem_q   <= '0;
            valid_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            valid_q <= valid_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign o_rdata = mem_q[head_q];
    assign o_count = count_q;
    assign o_mem   = mem_q;
    assign o_valid = valid_q;
    assign o_tail  = tail_q;

endmodule

// File: rtl/reg_32_writeback_unit.sv
// Write-side front end of the register file: arbitrates ALU/load
// results into a FIFO, drains one write per cycle, exposes hazards.
module reg_32_writeback_unit
    import reg_32_writeback_unit_pkg::*;
#(
    parameter int WORD_LEN   = REG_32_WORD_LEN,
    parameter int ADDR_LEN   = REG_32_ADDR_LEN,
    parameter int FIFO_DEPTH = 4,
    localparam int PW        = $clog2(FIFO_DEPTH),
    localparam int CW        = PW + 1,
    localparam int NREG      = 2 ** ADDR_LEN,
    localparam int EW        = ADDR_LEN + WORD_LEN
) (
    input  logic                i_sys_clk,
    input  logic                i_sys_rst_n,
    input  logic                i_alu_valid,
    output logic                o_alu_ready,
    input  logic [ADDR_LEN-1:0] i_alu_addr,
    input  logic [WORD_LEN-1:0] i_alu_data,
    input  logic                i_ld_valid,
    output logic                o_ld_ready,
    input  logic [ADDR_LEN-1:0] i_ld_addr,
    input  logic [WORD_LEN-1:0] i_ld_data,
    input  logic                i_wb_hold,
    output logic [ADDR_LEN-1:0] o_dest_addr,
    output logic [WORD_LEN-1:0] o_dest_write_val,
    output logic                o_dest_write_en,
    output logic [CW-1:0]       o_fifo_count,
    output logic [NREG-1:0]     o_pending_mask,
    input  logic [ADDR_LEN-1:0] i_query_addr,
    output logic                o_query_hit,
    output logic [WORD_LEN-1:0] o_query_data
);

    logic                         fifo_full;
    logic                         fifo_empty;
    logic [EW-1:0]                fifo_head;
    logic [FIFO_DEPTH-1:0][EW-1:0] fifo_mem;
    logic [FIFO_DEPTH-1:0]        fifo_valid;
    logic [PW-1:0]                fifo_tail;

    logic                ld_fire;
    logic                alu_fire;
    logic [ADDR_LEN-1:0] in_addr;
    logic [WORD_LEN-1:0] in_data;
    logic                push;
    logic                pop;

    logic [ADDR_LEN-1:0] addr_q, addr_d;
    logic [WORD_LEN-1:0] val_q, val_d;
    logic                en_q, en_d;

    logic [PW-1:0]       q_idx;
    logic [ADDR_LEN-1:0] e_addr;

    // Load has fixed priority; ALU only accepted when load is idle.
    assign o_ld_ready  = !fifo_full;
    assign o_alu_ready = !fifo_full && !i_ld_valid;
    assign ld_fire     = i_ld_valid && o_ld_ready;
    assign alu_fire    = i_alu_valid && o_alu_ready;
    assign in_addr     = ld_fire ? i_ld_addr : i_alu_addr;
    assign in_data     = ld_fire ? i_ld_data : i_alu_data;

    // Writes to r0 are acknowledged but dropped.
    assign push = (ld_fire || alu_fire) && (in_addr != '0);
    assign pop  = !i_wb_hold && !fifo_empty;

    reg_32_wb_fifo #(
        .W     (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_sys_clk),
        .i_rst_n (i_sys_rst_n),
        .i_push  (push),
        .i_wdata ({in_addr, in_data}),
        .i_pop   (pop),
        .o_rdata (fifo_head),
        .o_count (o_fifo_count),
        .o_full  (fifo_full),
        .o_empty (fifo_empty),
        .o_mem   (fifo_mem),
        .o_valid (fifo_valid),
        .o_tail  (fifo_tail)
    );

    // Output stage: load head on pop, otherwise hold addr/value.
    always_comb begin
        en_d   = pop;
        addr_d = addr_q;
        val_d  = val_q;
        if (pop) begin
            addr_d = fifo_head[EW-1 -: ADDR_LEN];
            val_d  = fifo_head[WORD_LEN-1:0];
        end
    end

    // Output register file-port drive.
    always_ff @(posedge i_sys_clk) begin
        if (!i_sys_rst_n) begin
            en_q   <= 1'b0;
            addr_q <= '0;
            val_q  <= '0;
        end else begin
            en_q   <= en_d;
            addr_q <= addr_d;
            val_q  <= val_d;
        end
    end

    assign o_dest_write_en  = en_q;
    assign o_dest_addr      = addr_q;
    assign o_dest_write_val = val_q;

    // Pending mask: every buffered destination plus the in-flight write.
    always_comb begin
        o_pending_mask = '0;
        if (en_q) begin
            o_pending_mask[addr_q] = 1'b1;
        end
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (fifo_valid[i]) begin
                o_pending_mask[fifo_mem[i][EW-1 -: ADDR_LEN]] = 1'b1;
            end
        end
        o_pending_mask[0] = 1'b0;
    end

    // Forwarding lookup: newest match wins, output stage is the fallback.
    always_comb begin
        o_query_hit  = 1'b0;
        o_query_data = '0;
        q_idx        = '0;
        e_addr       = '0;
        if (en_q && (addr_q == i_query_addr)) begin
            o_query_hit  = 1'b1;
            o_query_data = val_q;
        end
        for (int k = FIFO_DEPTH - 1; k >= 0; k--) begin
            q_idx  = fifo_tail - PW'(k + 1);
            e_addr = fifo_mem[q_idx][EW-1 -: ADDR_LEN];
            if ((CW'(k) < o_fifo_count) && (e_addr == i_query_addr)) begin
                o_query_hit  = 1'b1;
                o_query_data = fifo_mem[q_idx][WORD_LEN-1:0];
            end
        end
        if (i_query_addr == '0) begin
            o_query_hit  = 1'b0;
            o_query_data = '0;
        end
    end

endmodule

// File: tb/tb_reg_32_writeback_unit.sv
// Bench for reg_32_writeback_unit: directed scenarios then random
// traffic, all checked against a queue-based reference model.
module tb_reg_32_writeback_unit;

    logic        clk;
    logic        rst_n;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_addr;
    logic [31:0] alu_data;
    logic        ld_valid;
    logic        ld_ready;
    logic [4:0]  ld_addr;
    logic [31:0] ld_data;
    logic        wb_hold;
    logic [4:0]  dest_addr;
    logic [31:0] dest_val;
    logic        dest_en;
    logic [2:0]  fifo_count;
    logic [31:0] pmask;
    logic [4:0]  q_addr;
    logic        q_hit;
    logic [31:0] q_data;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    ent_t        mq[$];
    logic        m_en;
    logic [4:0]  m_addr;
    logic [31:0] m_val;
    int          n_tests;
    int          n_fail;

    reg_32_writeback_unit dut (
        .i_sys_clk        (clk),
        .i_sys_rst_n      (rst_n),
        .i_alu_valid      (alu_valid),
        .o_alu_ready      (alu_ready),
        .i_alu_addr       (alu_addr),
        .i_alu_data       (alu_data),
        .i_ld_valid       (ld_valid),
        .o_ld_ready       (ld_ready),
        .i_ld_addr        (ld_addr),
        .i_ld_data        (ld_data),
        .i_wb_hold        (wb_hold),
        .o_dest_addr      (dest_addr),
        .o_dest_write_val (dest_val),
        .o_dest_write_en  (dest_en),
        .o_fifo_count     (fifo_count),
        .o_pending_mask   (pmask),
        .i_query_addr     (q_addr),
        .o_query_hit      (q_hit),
        .o_query_data     (q_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic        full;
        logic [31:0] m;
        logic        hit;
        logic [31:0] hd;
        full = (mq.size() == 4);
        m = 32'h0;
        foreach (mq[i]) m[mq[i].a] = 1'b1;
        if (m_en) m[m_addr] = 1'b1;
        m[0] = 1'b0;
        hit = 1'b0;
        hd  = 32'h0;
        if (q_addr != 5'd0) begin
            for (int i = mq.size() - 1; i >= 0; i--) begin
                if (!hit && mq[i].a == q_addr) begin
                    hit = 1'b1;
                    hd  = mq[i].d;
                end
            end
            if (!hit && m_en && m_addr == q_addr) begin
                hit = 1'b1;
                hd  = m_val;
            end
        end
        chk("ld_ready", 32'(ld_ready), 32'(!full));
        chk("alu_ready", 32'(alu_ready), 32'(!full && !ld_valid));
        chk("count", 32'(fifo_count), 32'(mq.size()));
        chk("wr_en", 32'(dest_en), 32'(m_en));
        chk("wr_addr", 32'(dest_addr), 32'(m_addr));
        chk("wr_val", dest_val, m_val);
        chk("mask", pmask, m);
        chk("q_hit", 32'(q_hit), 32'(hit));
        chk("q_data", q_data, hd);
    endtask

    task automatic model_edge();
        logic full;
        logic ld_acc;
        logic alu_acc;
        ent_t e;
        if (!rst_n) begin
            mq.delete();
            m_en   = 1'b0;
            m_addr = 5'd0;
            m_val  = 32'd0;
        end else begin
            full    = (mq.size() == 4);
            ld_acc  = ld_valid && !full;
            alu_acc = alu_valid && !full && !ld_valid;
            if (!wb_hold && mq.size() > 0) begin
                e      = mq.pop_front();
                m_en   = 1'b1;
                m_addr = e.a;
                m_val  = e.d;
            end else begin
                m_en = 1'b0;
            end
            if (ld_acc && ld_addr != 5'd0)
                mq.push_back('{a: ld_addr, d: ld_data});
            else if (alu_acc && alu_addr != 5'd0)
                mq.push_back('{a: alu_addr, d: alu_data});
        end
    endtask

    task automatic cycle(input bit do_check = 1'b1);
        #1;
        if (do_check) check_all();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic drive(input logic lv, input logic [4:0] la,
                         input logic [31:0] ldd, input logic av,
                         input logic [4:0] aa, input logic [31:0] ad,
                         input logic h, input logic [4:0] qa);
        ld_valid  = lv;
        ld_addr   = la;
        ld_data   = ldd;
        alu_valid = av;
        alu_addr  = aa;
        alu_data  = ad;
        wb_hold   = h;
        q_addr    = qa;
    endtask

    task automatic idle(input int n, input logic h = 1'b0,
                        input logic [4:0] qa = 5'd0);
        drive(0, 0, 0, 0, 0, 0, h, qa);
        repeat (n) cycle();
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        m_en    = 1'b0;
        m_addr  = 5'd0;
        m_val   = 32'd0;
        rst_n   = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        cycle(1'b0);
        cycle(1'b0);
        rst_n = 1'b1;

        // single ALU write, r5
        drive(0, 0, 0, 1, 5'd5, 32'hDEADBEEF, 0, 5'd5);
        cycle();
        idle(4, 1'b0, 5'd5);

        // load beats ALU in the same cycle
        drive(1, 5'd3, 32'h11, 1, 5'd4, 32'h22, 0, 5'd3);
        cycle();
        drive(0, 0, 0, 1, 5'd4, 32'h22, 0, 5'd4);
        cycle();
        idle(4, 1'b0, 5'd4);

        // r0 write is accepted and dropped
        drive(0, 0, 0, 1, 5'd0, 32'hFFFFFFFF, 0, 5'd0);
        cycle();
        idle(2);

        // fill under hold, then drain
        for (int i = 1; i <= 5; i++) begin
            drive(0, 0, 0, 1, 5'(i), 32'h100 + 32'(i), 1, 5'(i));
            cycle();
        end
        idle(7, 1'b0, 5'd2);

        // two writes to r7; newest forwards
        drive(0, 0, 0, 1, 5'd7, 32'hA, 1, 5'd7);
        cycle();
        drive(0, 0, 0, 1, 5'd7, 32'hB, 1, 5'd7);
        cycle();
        idle(2, 1'b1, 5'd7);
        idle(4, 1'b0, 5'd7);

        // reset with three queued entries
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 1, 5'(9 + i), 32'h900 + 32'(i), 1, 5'd10);
            cycle();
        end
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 1, 5'd10);
        cycle();
        rst_n = 1'b1;
        idle(1, 1'b0, 5'd10);
        drive(0, 0, 0, 1, 5'd12, 32'hC0FFEE, 0, 5'd12);
        cycle();
        idle(3, 1'b0, 5'd12);

        // random traffic
        for (int n = 0; n < 500; n++) begin
            rst_n = ($urandom_range(0, 79) != 0);
            drive($urandom_range(0, 2) == 0, 5'($urandom_range(0, 7)),
                  $urandom, $urandom_range(0, 1) == 0,
                  5'($urandom_range(0, 7)), $urandom,
                  $urandom_range(0, 2) == 0, 5'($urandom_range(0, 7)));
            cycle();
        end
        rst_n = 1'b1;
        idle(6);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
